// File: rtl/cam_search_engine.sv
// Pipelined CAM with per-entry valid bits, supporting BCAM, TCAM and STCAM matching.
// Two-stage search pipeline: raw match vector, then priority/multi-hit/count results.
module cam_search_engine #(
  parameter int    DEPTH    = 8,
  parameter int    WIDTH    = 8,
  parameter string CAM_TYPE = "BCAM",
  localparam int   AW       = $clog2(DEPTH),
  localparam int   CW       = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic             inv_en,
  input  logic [AW-1:0]    inv_addr,
  input  logic             flush,
  input  logic             srch_valid,
  input  logic [WIDTH-1:0] srch_key,
  input  logic [WIDTH-1:0] srch_mask,
  output logic             res_valid,
  output logic [DEPTH-1:0] res_vector,
  output logic             res_hit,
  output logic [AW-1:0]    res_index,
  output logic             res_multi,
  output logic [CW-1:0]    res_count,
  output logic [CW-1:0]    occupancy
);

  localparam bit USE_SRCH_MASK   = (CAM_TYPE == "TCAM") || (CAM_TYPE == "STCAM");
  localparam bit USE_STORED_MASK = (CAM_TYPE == "STCAM");

  logic [WIDTH-1:0] stored [DEPTH];
  logic [WIDTH-1:0] smask  [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_next;
  logic [DEPTH-1:0] match_vec;
  logic [DEPTH-1:0] s1_vec;
  logic             s1_valid;
  logic [CW-1:0]    s1_count;

  function automatic logic [CW-1:0] count_ones(input logic [DEPTH-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + CW'(v[i]);
    return n;
  endfunction

  function automatic logic [AW-1:0] lowest_index(input logic [DEPTH-1:0] v);
    logic [AW-1:0] idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) if (v[i]) idx = AW'(i);
    return idx;
  endfunction

  function automatic logic entry_match(input logic [WIDTH-1:0] data,
                                       input logic [WIDTH-1:0] dmask,
                                       input logic [WIDTH-1:0] key,
                                       input logic [WIDTH-1:0] kmask);
    logic [WIDTH-1:0] ignore;
    ignore = (USE_SRCH_MASK ? kmask : '0) | (USE_STORED_MASK ? dmask : '0);
    return ((data ^ key) & ~ignore) == '0;
  endfunction

  // Flush beats invalidate, invalidate beats write on the same entry.
  always_comb begin
    // NOTE: default assignment first so no path leaves valid_next unassigned (no latch).
    valid_next = valid;
    if (flush) begin
      valid_next = '0;
    end else begin
      if (wr_en)  valid_next[wr_addr]  = 1'b1;
      if (inv_en) valid_next[inv_addr] = 1'b0;
    end
  end

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++)
      match_vec[i] = valid[i] && entry_match(stored[i], smask[i], srch_key, srch_mask);
  end

  // NOTE: storage is a flop array cleared by reset, so it cannot map to a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stored[i] <= '0;
        smask[i]  <= '0;
      end
    end else if (wr_en && !flush) begin
      stored[wr_addr] <= wr_data;
      smask[wr_addr]  <= wr_mask;
    end
  end

  // Occupancy is a registered popcount of the post-edge valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid     <= '0;
      occupancy <= '0;
    end else begin
      valid     <= valid_next;
      occupancy <= count_ones(valid_next);
    end
  end

  assign s1_count = count_ones(s1_vec);

  // Data registers hold when their stage is idle; only the valid flags advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid   <= 1'b0;
      s1_vec     <= '0;
      res_valid  <= 1'b0;
      res_vector <= '0;
      res_hit    <= 1'b0;
      res_index  <= '0;
      res_multi  <= 1'b0;
      res_count  <= '0;
    end else begin
      s1_valid  <= srch_valid;
      res_valid <= s1_valid;
      if (srch_valid) s1_vec <= match_vec;
      if (s1_valid) begin
        res_vector <= s1_vec;
        res_hit    <= |s1_vec;
        res_index  <= lowest_index(s1_vec);
        res_multi  <= s1_count > CW'(1);
        res_count  <= s1_count;
      end
    end
  end

endmodule

// File: doc/cam_search_engine.md
# cam_search_engine

Parametrised, pipelined content-addressable memory supporting binary (BCAM), ternary search-masked (TCAM) and stored-mask ternary (STCAM) matching, selected per instance. Adds per-entry valid bits, encoded-address write/invalidate, single-cycle flush, lowest-index priority encoding, multi-hit detection, match counting and an occupancy counter. It sits behind lookup front-ends and accepts one search per clock, with fixed 2-cycle result latency.

## Interface
- DEPTH, 8, number of entries (power of two, ≥2); AW = $clog2(DEPTH), CW = $clog2(DEPTH)+1
- WIDTH, 8, bits per entry and per key
- CAM_TYPE, "BCAM", match mode: "BCAM", "TCAM" or "STCAM"

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- wr_en  in  1  write entry wr_addr this edge
- wr_addr  in  AW  entry index for write
- wr_data  in  WIDTH  stored word
- wr_mask  in  WIDTH  stored don't-care bits (1 = ignore); stored in all modes, used only in STCAM
- inv_en  in  1  clear valid bit of inv_addr
- inv_addr  in  AW  entry index for invalidate
- flush  in  1  clear all valid bits
- srch_valid  in  1  search request this cycle
- srch_key  in  WIDTH  search key
- srch_mask  in  WIDTH  search don't-care bits (1 = ignore); used in TCAM and STCAM, ignored in BCAM
- res_valid  out  1  result outputs valid this cycle
- res_vector  out  DEPTH  per-entry match bits (bit i = entry i)
- res_hit  out  1  any match
- res_index  out  AW  lowest matching index; 0 when no hit
- res_multi  out  1  two or more matches
- res_count  out  CW  number of matching entries
- occupancy  out  CW  number of valid entries

## Operation
- Entry i matches only when valid[i] = 1 and:
  - BCAM: stored[i] == key
  - TCAM: ((stored[i] ^ key) & ~srch_mask) == 0
  - STCAM: ((stored[i] ^ key) & ~(smask[i] | srch_mask)) == 0
- Write: on wr_en, store wr_data and wr_mask, and set valid[wr_addr].
- Invalidate: on inv_en, clear valid[inv_addr]. Data is retained.
- Flush: clear every valid bit. Storage is untouched.
- Same-edge priority: flush > inv_en > wr_en.
  - flush with wr_en: the write is dropped.
  - inv_en and wr_en to the same address: the entry ends up invalid.
  - inv_en and wr_en to different addresses: both take effect.
- Rewriting an already-valid entry leaves occupancy unchanged.
- Occupancy is recomputed from the valid bits, so it is always equal to popcount(valid).
- Pipeline:
  - Stage 1 registers the raw match vector and a stage-1 valid flag.
  - Stage 2 registers res_vector, res_hit, res_index, res_multi, res_count and res_valid.
- When a stage is not valid, its data registers hold their previous values. res_valid distinguishes fresh results.
- res_count arithmetic: CW bits, so DEPTH matches fit without overflow.

## Timing
- Asynchronous reset (rst = 0) clears:
  - all valid bits, all stored data and masks
  - both pipeline stages
  - every output: res_* = 0, occupancy = 0
- Reset asserted mid-search discards in-flight searches. No res_valid pulse follows release.
- Search latency: request sampled at edge N → res_valid = 1 after edge N+1, held for one cycle per request.
- Throughput: back-to-back srch_valid gives back-to-back res_valid.
- No backpressure: results are not held and must be consumed in their valid cycle.
- Search sampled at the same edge as a write, invalidate or flush compares against pre-edge contents.
- Search at edge N+1 sees all updates from edge N.
- occupancy updates on the edge after the write, invalidate or flush.

## Test plan
- Reset → occupancy = 0, res_valid = 0. Write entries 0 and 4 with 0x01 (mask 0x00) → occupancy = 2. BCAM search 0x01 → two cycles later: res_vector = 0x11, res_index = 0, res_multi = 1, res_count = 2.
- TCAM: entries 0 and 7 = 0x81, others hold 0x00 and are valid. Key 0x00, srch_mask 0x81 → res_vector = 0xFF, res_count = 8. Same key with mask 0x00 → res_vector = 0x7E.
- STCAM: entry 1 = 0x40 with stored mask 0x02. Key 0x42, srch_mask 0x00 → res_vector bit1 = 1, res_index = 1. Key 0x44 → bit1 = 0.
- Invalidate entry 0 while searching 0x01 at the same edge → that result still shows bit0 = 1. Next search → res_vector = 0x10, occupancy decrements by 1.
- Flush with wr_en to entry 3 at the same edge → occupancy = 0 and all subsequent searches miss: res_hit = 0, res_index = 0.
- Searches on 3 consecutive cycles, then rst pulsed low mid-stream → no res_valid after release. Outputs read 0 until a new search.
